// File: rtl/vga_fb_arbiter_if.sv
`timescale 1ns/1ps
// Framebuffer port bundle: display read port, host request port and single-port RAM request.
// The arbiter uses the master view; requesters and the RAM model use the slave view.
interface vga_fb_arbiter_if #(
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned DATA_W = 8
);
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_rdata;
    logic              disp_rvalid;

    logic              host_valid;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_ready;
    logic [DATA_W-1:0] host_rdata;
    logic              host_rvalid;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  disp_req, disp_addr, host_valid, host_we, host_addr, host_wdata, mem_rdata,
        output disp_rdata, disp_rvalid, host_ready, host_rdata, host_rvalid,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output disp_req, disp_addr, host_valid, host_we, host_addr, host_wdata, mem_rdata,
        input  disp_rdata, disp_rvalid, host_ready, host_rdata, host_rvalid,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/vga_fb_arbiter.sv
`timescale 1ns/1ps
// Framebuffer RAM arbiter: display scanout has fixed priority over host access on one RAM port.
// Defining VGA_FB_ARBITER_STALL_CNT_EN adds the saturating host_stall_cnt output.
module vga_fb_arbiter #(
    parameter int unsigned ADDR_W     = 19,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned RD_LATENCY = 1   // legal range 1..4
) (
    input  logic             clk,
    input  logic             reset_n,
    vga_fb_arbiter_if.master bus
`ifdef VGA_FB_ARBITER_STALL_CNT_EN
    ,
    output logic [15:0]      host_stall_cnt
`endif
);
    typedef enum logic [1:0] {GrIdle, GrDisp, GrHostRd, GrHostWr} grant_e;
    typedef enum logic [1:0] {TagNone, TagDisp, TagHost} tag_e;

    grant_e            grant_q, grant_d;
    tag_e              tag_in, tag_out;
    tag_e              tag_q [RD_LATENCY];
    logic              mem_en_q, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] disp_hold_q, host_hold_q;
    logic              host_ready;
    logic              disp_rvalid, host_rvalid;

    // Ready is forced low in reset so no transfer is implied while the block is held.
    assign host_ready     = reset_n & ~bus.disp_req;
    assign bus.host_ready = host_ready;

    always_comb begin
        grant_d = GrIdle;
        if (bus.disp_req) begin
            grant_d = GrDisp;
        end else if (bus.host_valid) begin
            grant_d = bus.host_we ? GrHostWr : GrHostRd;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_q     <= GrIdle;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            grant_q  <= grant_d;
            mem_en_q <= (grant_d != GrIdle);
            mem_we_q <= (grant_d == GrHostWr);
            if (grant_d == GrDisp) begin
                mem_addr_q <= bus.disp_addr;
            end else if (grant_d != GrIdle) begin
                mem_addr_q <= bus.host_addr;
            end
            if (grant_d == GrHostWr) begin
                mem_wdata_q <= bus.host_wdata;
            end
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    always_comb begin
        tag_in = TagNone;
        unique case (grant_q)
            GrDisp:   tag_in = TagDisp;
            GrHostRd: tag_in = TagHost;
            default:  tag_in = TagNone;
        endcase
    end

    // Tag enters alongside the RAM request and emerges when its read data does.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                tag_q[i] <= TagNone;
            end
        end else begin
            tag_q[0] <= tag_in;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign tag_out     = tag_q[RD_LATENCY-1];
    assign disp_rvalid = (tag_out == TagDisp);
    assign host_rvalid = (tag_out == TagHost);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            disp_hold_q <= '0;
            host_hold_q <= '0;
        end else begin
            if (disp_rvalid) disp_hold_q <= bus.mem_rdata;
            if (host_rvalid) host_hold_q <= bus.mem_rdata;
        end
    end

    assign bus.disp_rvalid = disp_rvalid;
    assign bus.host_rvalid = host_rvalid;
    assign bus.disp_rdata  = disp_rvalid ? bus.mem_rdata : disp_hold_q;
    assign bus.host_rdata  = host_rvalid ? bus.mem_rdata : host_hold_q;

`ifdef VGA_FB_ARBITER_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
        end else if (bus.host_valid && !host_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign host_stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_vga_fb_arbiter.sv
`timescale 1ns/1ps
// Directed bench for vga_fb_arbiter: two instances (read latency 1 and 3) share the stimulus,
// each with its own RAM model and return scoreboard.
module tb_vga_fb_arbiter;
    localparam int unsigned AW    = 19;
    localparam int unsigned DW    = 8;
    localparam int unsigned LAT_A = 1;
    localparam int unsigned LAT_B = 3;

    typedef struct {
        bit          host;
        logic [7:0]  data;
        int unsigned due;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n;
    int unsigned   cyc = 0;
    int            errors;
    int            checks;

    logic          d_req;
    logic [AW-1:0] d_addr;
    logic          h_valid;
    logic          h_we;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_wdata;

    logic [DW-1:0] ref_mem [1024];
    logic [DW-1:0] ram_a [1024];
    logic [DW-1:0] ram_b [1024];
    logic [DW-1:0] pipe_a [LAT_A];
    logic [DW-1:0] pipe_b [LAT_B];
    logic          ram_ready = 1'b0;
    exp_t          q_a[$];
    exp_t          q_b[$];
    int unsigned   we_a = 0;
    int unsigned   we_b = 0;
    logic [15:0]   stall_a;
    logic [15:0]   stall_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vga_fb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
    vga_fb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

    assign bus_a.disp_req   = d_req;
    assign bus_a.disp_addr  = d_addr;
    assign bus_a.host_valid = h_valid;
    assign bus_a.host_we    = h_we;
    assign bus_a.host_addr  = h_addr;
    assign bus_a.host_wdata = h_wdata;
    assign bus_b.disp_req   = d_req;
    assign bus_b.disp_addr  = d_addr;
    assign bus_b.host_valid = h_valid;
    assign bus_b.host_we    = h_we;
    assign bus_b.host_addr  = h_addr;
    assign bus_b.host_wdata = h_wdata;

    vga_fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT_A)) u_dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_a)
`ifdef VGA_FB_ARBITER_STALL_CNT_EN
        ,
        .host_stall_cnt (stall_a)
`endif
    );

    vga_fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT_B)) u_dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_b)
`ifdef VGA_FB_ARBITER_STALL_CNT_EN
        ,
        .host_stall_cnt (stall_b)
`endif
    );

`ifndef VGA_FB_ARBITER_STALL_CNT_EN
    assign stall_a = '0;
    assign stall_b = '0;
`endif

    function automatic logic [7:0] init_val(input int i);
        return (i == 256) ? 8'hA5 : (8'(i) ^ 8'h5A);
    endfunction

    // RAM models: read data appears LAT cycles after the mem_en cycle; X when nothing was read.
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 1024; i++) begin
                ram_a[i] <= init_val(i);
                ram_b[i] <= init_val(i);
            end
            ram_ready <= 1'b1;
        end else begin
            if (bus_a.mem_en && bus_a.mem_we) ram_a[bus_a.mem_addr[9:0]] <= bus_a.mem_wdata;
            if (bus_b.mem_en && bus_b.mem_we) ram_b[bus_b.mem_addr[9:0]] <= bus_b.mem_wdata;
        end
        pipe_a[0] <= (bus_a.mem_en && !bus_a.mem_we) ? ram_a[bus_a.mem_addr[9:0]] : 'x;
        pipe_b[0] <= (bus_b.mem_en && !bus_b.mem_we) ? ram_b[bus_b.mem_addr[9:0]] : 'x;
        for (int i = 1; i < LAT_A; i++) pipe_a[i] <= pipe_a[i-1];
        for (int i = 1; i < LAT_B; i++) pipe_b[i] <= pipe_b[i-1];
    end

    assign bus_a.mem_rdata = pipe_a[LAT_A-1];
    assign bus_b.mem_rdata = pipe_b[LAT_B-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Return monitors: pop one expectation per rvalid, check source, data and arrival cycle.
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (bus_a.mem_en && bus_a.mem_we) we_a++;
        if (reset_n) begin
            if (bus_a.disp_rvalid || bus_a.host_rvalid) begin
                if (q_a.size() == 0) begin
                    check("a_unexpected_rvalid", {bus_a.disp_rvalid, bus_a.host_rvalid}, 0);
                end else begin
                    e = q_a.pop_front();
                    check("a_rvalid_route", {bus_a.disp_rvalid, bus_a.host_rvalid},
                          e.host ? 32'd1 : 32'd2);
                    check("a_rdata", e.host ? bus_a.host_rdata : bus_a.disp_rdata, e.data);
                    check("a_rvalid_cycle", cyc, e.due);
                end
            end else if (q_a.size() > 0 && q_a[0].due <= cyc) begin
                check("a_missing_rvalid", bus_a.disp_rvalid | bus_a.host_rvalid, 1);
                void'(q_a.pop_front());
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (bus_b.mem_en && bus_b.mem_we) we_b++;
        if (reset_n) begin
            if (bus_b.disp_rvalid || bus_b.host_rvalid) begin
                if (q_b.size() == 0) begin
                    check("b_unexpected_rvalid", {bus_b.disp_rvalid, bus_b.host_rvalid}, 0);
                end else begin
                    e = q_b.pop_front();
                    check("b_rvalid_route", {bus_b.disp_rvalid, bus_b.host_rvalid},
                          e.host ? 32'd1 : 32'd2);
                    check("b_rdata", e.host ? bus_b.host_rdata : bus_b.disp_rdata, e.data);
                    check("b_rvalid_cycle", cyc, e.due);
                end
            end else if (q_b.size() > 0 && q_b[0].due <= cyc) begin
                check("b_missing_rvalid", bus_b.disp_rvalid | bus_b.host_rvalid, 1);
                void'(q_b.pop_front());
            end
        end
    end

    // One request cycle; the bench decides acceptance and pushes the expected returns.
    task automatic drive(input bit dr, input int da, input bit hv, input bit hw, input int ha,
                         input logic [7:0] hd);
        @(posedge clk);
        #1;
        d_req   = dr;
        d_addr  = AW'(da);
        h_valid = hv;
        h_we    = hw;
        h_addr  = AW'(ha);
        h_wdata = hd;
        if (dr) begin
            q_a.push_back('{host: 1'b0, data: ref_mem[da % 1024], due: cyc + 1 + LAT_A});
            q_b.push_back('{host: 1'b0, data: ref_mem[da % 1024], due: cyc + 1 + LAT_B});
        end else if (hv) begin
            if (hw) begin
                ref_mem[ha % 1024] = hd;
            end else begin
                q_a.push_back('{host: 1'b1, data: ref_mem[ha % 1024], due: cyc + 1 + LAT_A});
                q_b.push_back('{host: 1'b1, data: ref_mem[ha % 1024], due: cyc + 1 + LAT_B});
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0, 1'b0, 0, 8'h00);
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_a_ctrl"}, {bus_a.mem_en, bus_a.mem_we, bus_a.disp_rvalid,
                                 bus_a.host_rvalid, bus_a.host_ready}, 0);
        check({pfx, "_a_addr"}, bus_a.mem_addr, 0);
        check({pfx, "_a_data"}, {bus_a.mem_wdata, bus_a.disp_rdata, bus_a.host_rdata}, 0);
        check({pfx, "_b_ctrl"}, {bus_b.mem_en, bus_b.mem_we, bus_b.disp_rvalid,
                                 bus_b.host_rvalid, bus_b.host_ready}, 0);
        check({pfx, "_b_addr"}, bus_b.mem_addr, 0);
        check({pfx, "_b_data"}, {bus_b.mem_wdata, bus_b.disp_rdata, bus_b.host_rdata}, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed cycle %0d expected completion", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        int unsigned w0a, w0b, hg;
        errors  = 0;
        checks  = 0;
        d_req   = 1'b0;
        d_addr  = '0;
        h_valid = 1'b1;
        h_we    = 1'b0;
        h_addr  = '0;
        h_wdata = '0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
        reset_n = 1'b0;

        // Reset state, with a pending host request that must not see ready.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        h_valid = 1'b0;

        // Single display read of 0x100.
        drive(1'b1, 'h100, 1'b0, 1'b0, 0, 8'h00);
        drive(1'b0, 0, 1'b0, 1'b0, 0, 8'h00);
        @(negedge clk);
        check("disp_mem_req_a", {bus_a.mem_en, bus_a.mem_we}, 2'b10);
        check("disp_mem_addr_a", bus_a.mem_addr, 'h100);
        check("disp_mem_req_b", {bus_b.mem_en, bus_b.mem_we}, 2'b10);
        check("disp_mem_addr_b", bus_b.mem_addr, 'h100);
        idle(2);
        @(negedge clk);
        check("disp_rdata_hold_a", {bus_a.disp_rvalid, bus_a.disp_rdata}, 9'h0A5);
        idle(3);

        // Collision: host write held off by three display cycles.
        w0a = we_a;
        w0b = we_b;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 'h20 + i, 1'b1, 1'b1, 'h10, 8'h3C);
            @(negedge clk);
            check("collision_ready_low", {bus_a.host_ready, bus_b.host_ready}, 2'b00);
        end
        drive(1'b0, 0, 1'b1, 1'b1, 'h10, 8'h3C);
        @(negedge clk);
        check("collision_ready_high", {bus_a.host_ready, bus_b.host_ready}, 2'b11);
        idle(1);
        @(negedge clk);
        check("collision_write_a", {bus_a.mem_en, bus_a.mem_we, bus_a.mem_wdata}, 10'h33C);
        check("collision_waddr_a", bus_a.mem_addr, 'h10);
        check("collision_write_b", {bus_b.mem_en, bus_b.mem_we, bus_b.mem_wdata}, 10'h33C);
        check("collision_waddr_b", bus_b.mem_addr, 'h10);
        idle(5);
        check("collision_one_write_a", we_a - w0a, 1);
        check("collision_one_write_b", we_b - w0b, 1);

        // Interleaved reads: disp, host (reads back the write), disp.
        drive(1'b1, 'h30, 1'b0, 1'b0, 0, 8'h00);
        drive(1'b0, 0, 1'b1, 1'b0, 'h10, 8'h00);
        drive(1'b1, 'h31, 1'b0, 1'b0, 0, 8'h00);
        idle(7);

        // Reset one cycle after a display read issues; the read must never return.
        drive(1'b1, 'h40, 1'b0, 1'b0, 0, 8'h00);
        @(posedge clk);
        #1;
        d_req   = 1'b0;
        h_valid = 1'b1;
        reset_n = 1'b0;
        q_a.delete();
        q_b.delete();
        #1;
        check_zero("inflight_reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        h_valid = 1'b0;
        idle(7);

        // Full visible line with a host read waiting throughout.
        hg = 0;
        for (int i = 0; i < 800; i++) begin
            drive(1'b1, i, 1'b1, 1'b0, 'h3FF, 8'h00);
            @(negedge clk);
            if (bus_a.mem_en && bus_a.mem_addr == AW'('h3FF)) hg++;
            if (bus_b.mem_en && bus_b.mem_addr == AW'('h3FF)) hg++;
        end
        check("line_host_grants", hg, 0);
        drive(1'b0, 0, 1'b1, 1'b0, 'h3FF, 8'h00);
        @(negedge clk);
        check("line_end_ready", {bus_a.host_ready, bus_b.host_ready}, 2'b11);
        idle(1);
        @(negedge clk);
        check("line_end_grant_a", {bus_a.mem_en, bus_a.mem_we}, 2'b10);
        check("line_end_addr_a", bus_a.mem_addr, 'h3FF);
        check("line_end_grant_b", {bus_b.mem_en, bus_b.mem_we}, 2'b10);
        idle(6);

`ifdef VGA_FB_ARBITER_STALL_CNT_EN
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("stall_reset", {stall_a, stall_b}, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) drive(1'b1, i, 1'b1, 1'b1, 'h5, 8'h77);
        @(negedge clk);
        check("stall_count_9", {stall_a, stall_b}, {16'd9, 16'd9});
        for (int i = 10; i < 70000; i++) drive(1'b1, i, 1'b1, 1'b1, 'h5, 8'h77);
        @(negedge clk);
        check("stall_saturate", {stall_a, stall_b}, 32'hFFFF_FFFF);
        for (int i = 0; i < 5; i++) drive(1'b1, i, 1'b1, 1'b1, 'h5, 8'h77);
        @(negedge clk);
        check("stall_hold", {stall_a, stall_b}, 32'hFFFF_FFFF);
        idle(6);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("stall_reset_after_sat", {stall_a, stall_b}, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(2);
`endif

        idle(2);
        check("drain_a", q_a.size(), 0);
        check("drain_b", q_b.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vga_fb_arbiter.md
VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 19: framebuffer word-address width.
REQ-002 SHALL have parameter DATA_W, default 8: framebuffer word width.
REQ-003 SHALL have parameter RD_LATENCY, default 1, legal range 1..4: memory read latency, in cycles from mem_en to mem_rdata.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port disp_req, input, 1 bit: display scanout read request, one word per cycle.
REQ-007 SHALL have port disp_addr, input, ADDR_W: display read address.
REQ-008 SHALL have ports disp_rdata (output, DATA_W) and disp_rvalid (output, 1): display read return.
REQ-009 SHALL have ports host_valid, host_we (inputs, 1 each) and host_addr (input, ADDR_W): host request, write when host_we=1.
REQ-010 SHALL have ports host_wdata (input, DATA_W) and host_ready (output, 1): host write data and acceptance.
REQ-011 SHALL have ports host_rdata (output, DATA_W) and host_rvalid (output, 1): host read return.
REQ-012 SHALL have ports mem_en, mem_we (outputs, 1 each), mem_addr (output, ADDR_W) and mem_wdata (output, DATA_W): single-port RAM request.
REQ-013 SHALL have port mem_rdata, input, DATA_W: RAM read data.

Function
REQ-014 SHALL assign one RAM access per cycle, with fixed priority: display over host.
REQ-015 SHALL drive host_ready = !disp_req, combinationally; a host transfer occurs on a cycle where host_valid && host_ready.
REQ-016 SHALL register the mem_* outputs: a request accepted at edge N appears on mem_* during cycle N+1.
REQ-017 SHALL hold mem_en=0 and mem_we=0 in a cycle with no accepted request; mem_addr and mem_wdata then hold their last value.
REQ-018 SHALL keep a registered grant state with values IDLE, DISP and HOST_RD/HOST_WR, updated every edge from that cycle's arbitration result.
REQ-019 SHALL carry a return-tag shift register of depth RD_LATENCY (NONE/DISP/HOST) that routes mem_rdata to the originator and pulses its rvalid for exactly one cycle.
REQ-020 SHALL deliver a display read with a fixed latency of 1+RD_LATENCY cycles from disp_req high to disp_rvalid high (default 2; the timing generator's SYNC_LATENCY is set to this).
REQ-021 SHALL return host reads with the same latency; host writes produce no rvalid.
REQ-022 SHALL return reads in issue order, with back-to-back requests giving back-to-back rvalid.
REQ-023 On simultaneous disp_req and host_valid: display granted, host_ready=0, and the host request is held by the requester unchanged.
REQ-024 SHALL give a host waiting across a whole visible line no grant; it is granted on the first cycle disp_req=0.
REQ-025 SHALL hold disp_rdata and host_rdata at their last returned value when the matching rvalid=0.

Reset
REQ-026 While reset_n=0: mem_en, mem_we, disp_rvalid and host_rvalid = 0; mem_addr, mem_wdata, disp_rdata and host_rdata = 0; grant = IDLE; all tags = NONE.
REQ-027 Reset mid-operation SHALL discard in-flight reads: no rvalid after reset_n rises for requests issued before reset.
REQ-028 host_ready SHALL be 0 while reset_n=0.

Configuration
REQ-029 With macro VGA_FB_ARBITER_STALL_CNT_EN defined, the block SHALL add output host_stall_cnt (16 bits), which counts cycles with host_valid && !host_ready, saturates at 16'hFFFF, and resets to 0.
REQ-030 Without VGA_FB_ARBITER_STALL_CNT_EN, the host_stall_cnt port and counter SHALL be absent and function SHALL be otherwise identical.

Verification
REQ-031 Display read only: disp_req=1, disp_addr=0x100 for 1 cycle, mem_rdata=0xA5 -> mem_en=1 with mem_addr=0x100 at cycle+1, and disp_rvalid=1 with disp_rdata=0xA5 at cycle+2; no host_rvalid.
REQ-032 Collision: disp_req=1 and host_valid=1, host_we=1, host_addr=0x10, host_wdata=0x3C for 3 cycles, then disp_req=0 -> host_ready=0 for 3 cycles, then 1; exactly one mem_we=1 cycle with mem_addr=0x10 and mem_wdata=0x3C.
REQ-033 Interleaved reads: disp, host, disp on consecutive cycles, with RD_LATENCY=3 -> rvalid order disp, host, disp, each 4 cycles after its request, and data routed correctly.
REQ-034 Reset in flight: reset_n low for 1 cycle, 1 cycle after a disp read is issued -> no disp_rvalid afterwards, and all outputs 0 during reset.
REQ-035 Stall counter (macro defined): host_valid=1 with disp_req=1 for 70000 cycles -> host_stall_cnt=16'hFFFF, holding; reset -> 0.
REQ-036 Full-line scanout: disp_req high for 800 cycles with host_valid=1 -> zero host grants during the line, and host granted the first cycle after.
